// File: rtl/lr_shifter_pkg.sv
// Shared constants for the SPI-lite transmit shifter.
package lr_shifter_pkg;

    // Shift direction encoding carried on sh_rl
    localparam logic SH_LEFT  = 1'b1;  // MSB-first
    localparam logic SH_RIGHT = 1'b0;  // LSB-first

endpackage : lr_shifter_pkg

// File: rtl/lr_shifter.sv
// Parallel-load, serial-out transmit shifter with selectable bit order.
// A loaded word is presented one bit at a time on sdo; done flags that
// every loaded bit has been shifted out.
module lr_shifter
    import lr_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             ld,
    input  logic             sh_en,
    input  logic             sh_rl,
    output logic             sdo,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    // Shift register: load has priority over shift; shifts zero-fill
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (ld) begin
            shreg <= data;
        end else if (sh_en) begin
            if (sh_rl == SH_LEFT) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    // Remaining-bit counter: restarts on load, saturates at zero on shift
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= CNT_W'(WIDTH);
        end else if (sh_en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Output bit selected by direction; done decoded from the count
    always_comb begin
        sdo  = (sh_rl == SH_LEFT) ? shreg[WIDTH-1] : shreg[0];
        done = (cnt == '0);
    end

endmodule : lr_shifter

// File: tb/tb_lr_shifter.sv
// Self-checking bench for lr_shifter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_lr_shifter;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] data  = '0;
    logic         ld    = 1'b0;
    logic         sh_en = 1'b0;
    logic         sh_rl = 1'b0;
    logic         sdo;
    logic         done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: word value as an integer, bits remaining to send
    int unsigned m_val;
    int          m_left;

    lr_shifter #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .data  (data),
        .ld    (ld),
        .sh_en (sh_en),
        .sh_rl (sh_rl),
        .sdo   (sdo),
        .done  (done)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: shifting left doubles the value modulo 2^W, right halves it
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_val  <= 0;
            m_left <= 0;
        end else if (ld) begin
            m_val  <= int'(data);
            m_left <= W;
        end else if (sh_en) begin
            m_val  <= sh_rl ? ((m_val * 2) % (1 << W)) : (m_val / 2);
            m_left <= (m_left > 0) ? m_left - 1 : 0;
        end
    end

    // Continuous comparison against the model on the falling edge
    always @(negedge clk_i) begin
        if (chk_en && rst_n) begin
            check("model_sdo", 32'(sdo),
                  sh_rl ? 32'((m_val >> (W - 1)) & 1) : 32'(m_val & 1));
            check("model_done", 32'(done), 32'(m_left == 0));
            check("model_reg", 32'(dut.shreg), 32'(m_val));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d);
        data = d;
        ld   = 1'b1;
        step();
        ld   = 1'b0;
    endtask

    initial begin
        logic [W-1:0] msb_seq;
        logic [W-1:0] lsb_seq;
        msb_seq = 8'b1100_0100;  // C4 sent MSB-first, index 7 first
        lsb_seq = 8'b1100_0100;  // C4 sent LSB-first, index 0 first

        // Reset pulse of 2 ns between edges; outputs settle without a clock
        @(posedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("reset_sdo", 32'(sdo), 32'd0);
        check("reset_done", 32'(done), 32'd1);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // MSB-first, one shift every 5 cycles
        sh_rl = 1'b1;
        load(8'hC4);
        check("msb_model_pin", 32'(m_val), 32'h0C4);
        check("msb_done_after_load", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_bit%0d", i), 32'(sdo), 32'(msb_seq[7-i]));
            check($sformatf("msb_done%0d", i), 32'(done), 32'd0);
            sh_en = 1'b1;
            step();
            sh_en = 1'b0;
            for (int g = 0; g < 4; g++) step();
        end
        check("msb_done_end", 32'(done), 32'd1);
        check("msb_sdo_end", 32'(sdo), 32'd0);

        // LSB-first, back-to-back shifts
        sh_rl = 1'b0;
        load(8'hC4);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_bit%0d", i), 32'(sdo), 32'(lsb_seq[i]));
            check($sformatf("lsb_done%0d", i), 32'(done), 32'd0);
            sh_en = 1'b1;
            step();
        end
        sh_en = 1'b0;
        check("lsb_done_end", 32'(done), 32'd1);
        check("lsb_sdo_end", 32'(sdo), 32'd0);

        // Load beats shift in the same cycle
        sh_rl = 1'b1;
        data  = 8'h81;
        ld    = 1'b1;
        sh_en = 1'b1;
        step();
        ld    = 1'b0;
        sh_en = 1'b0;
        check("prio_reg", 32'(dut.shreg), 32'h81);
        check("prio_cnt", 32'(dut.cnt), 32'd8);
        check("prio_sdo", 32'(sdo), 32'd1);

        // Direction toggle without shifting
        sh_rl = 1'b1;
        load(8'h01);
        check("tog_sdo_left", 32'(sdo), 32'd0);
        sh_rl = 1'b0;
        #1;
        check("tog_sdo_right", 32'(sdo), 32'd1);
        check("tog_reg", 32'(dut.shreg), 32'h01);
        step();

        // Reload mid-transfer, then over-shift
        sh_rl = 1'b1;
        load(8'hFF);
        sh_en = 1'b1;
        repeat (3) step();
        sh_en = 1'b0;
        load(8'h00);
        check("reload_sdo", 32'(sdo), 32'd0);
        check("reload_cnt", 32'(dut.cnt), 32'd8);
        sh_en = 1'b1;
        repeat (10) step();
        sh_en = 1'b0;
        check("over_cnt", 32'(dut.cnt), 32'd0);
        check("over_done", 32'(done), 32'd1);
        check("over_sdo", 32'(sdo), 32'd0);

        // Reset mid-transfer aborts it
        load(8'hFF);
        sh_en = 1'b1;
        repeat (2) step();
        sh_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_sdo", 32'(sdo), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_reg", 32'(dut.shreg), 32'h00);
        #1 rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            data  = W'($urandom);
            ld    = ($urandom_range(0, 7) == 0);
            sh_en = ($urandom_range(0, 1) == 1);
            sh_rl = ($urandom_range(0, 1) == 1);
            step();
        end
        ld    = 1'b0;
        sh_en = 1'b0;
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_lr_shifter
